// File: rtl/fft_stage_controller.sv
// Sequencer for an in-place radix-2 DIT FFT: walks LOG2N stages, issuing one
// butterfly per cycle, with registered read, twiddle and write-back addresses.
// Optional feature: define FFT_CTRL_STALL_EN to add the stall_i input, which
// holds the butterfly sequence while asserted in the run state.
module fft_stage_controller #(
  parameter int unsigned LOG2N = 5,
  parameter int unsigned AW    = LOG2N
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
`ifdef FFT_CTRL_STALL_EN
  input  logic             stall_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [AW-1:0]    rd_addr_a_o,
  output logic [AW-1:0]    rd_addr_b_o,
  output logic [LOG2N-2:0] tw_addr_o,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_a_o,
  output logic [AW-1:0]    wr_addr_b_o
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned TW = LOG2N - 1;
  localparam logic [KW-1:0] KLast = {KW{1'b1}};
  localparam logic [SW-1:0] SLast = SW'(LOG2N - 1);

  typedef enum logic [2:0] {StIdle, StRun, StGap, StFlush, StDone} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
  logic [TW-1:0] tw_addr_q, tw_addr_d;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_a_q, wr_addr_b_q;
  logic          busy_q, done_q;
  logic          stall;

`ifdef FFT_CTRL_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // Next state and butterfly counters; k_q is advanced only once it has been issued.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    rd_en_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          s_d     = '0;
          k_d     = '0;
          rd_en_d = 1'b1;
        end
      end
      StRun: begin
        if (rd_en_q && (k_q == KLast)) begin
          k_d     = '0;
          state_d = (s_q == SLast) ? StFlush : StGap;
        end else begin
          if (rd_en_q) k_d = k_q + KW'(1);
          rd_en_d = ~stall;
        end
      end
      StGap: begin
        state_d = StRun;
        s_d     = s_q + SW'(1);
        k_d     = '0;
        rd_en_d = 1'b1;
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Address generation for the butterfly about to be issued.
  always_comb begin
    logic [AW-1:0] kx, span, pos, grp, tw_full;
    kx          = AW'(k_d);
    span        = AW'(1) << s_d;
    pos         = kx & (span - AW'(1));
    grp         = kx >> s_d;
    rd_addr_a_d = (grp << (32'(s_d) + 32'd1)) | pos;
    rd_addr_b_d = rd_addr_a_d + span;
    tw_full     = pos << (KW - 32'(s_d));
    tw_addr_d   = TW'(tw_full);
  end

  // State, counters and registered outputs; write side trails the read side by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      s_q         <= '0;
      k_q         <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      rd_en_q     <= rd_en_d;
      // Addresses hold across gaps and stalls.
      if (rd_en_d) begin
        rd_addr_a_q <= rd_addr_a_d;
        rd_addr_b_q <= rd_addr_b_d;
        tw_addr_q   <= tw_addr_d;
      end
      wr_en_q     <= rd_en_q;
      wr_addr_a_q <= rd_addr_a_q;
      wr_addr_b_q <= rd_addr_b_q;
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_addr_a_q;
  assign rd_addr_b_o = rd_addr_b_q;
  assign tw_addr_o   = tw_addr_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_a_o = wr_addr_a_q;
  assign wr_addr_b_o = wr_addr_b_q;

endmodule

// File: tb/tb_fft_stage_controller.sv
// Bench for fft_stage_controller: instances with LOG2N=3 and LOG2N=5, compared
// cycle by cycle against a stage/group/position trace model.
module tb_fft_stage_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic start3, start5;
`ifdef FFT_CTRL_STALL_EN
  logic stall3, stall5;
`endif

  logic       busy3, done3, rd3, wr3;
  logic [2:0] ra3, rb3, wa3, wb3;
  logic [1:0] tw3;
  logic       busy5, done5, rd5, wr5;
  logic [4:0] ra5, rb5, wa5, wb5;
  logic [3:0] tw5;

  always #5 clk = ~clk;

  fft_stage_controller #(.LOG2N(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3),
`ifdef FFT_CTRL_STALL_EN
    .stall_i(stall3),
`endif
    .busy_o(busy3), .done_o(done3), .rd_en_o(rd3), .rd_addr_a_o(ra3), .rd_addr_b_o(rb3),
    .tw_addr_o(tw3), .wr_en_o(wr3), .wr_addr_a_o(wa3), .wr_addr_b_o(wb3)
  );

  fft_stage_controller #(.LOG2N(5)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start5),
`ifdef FFT_CTRL_STALL_EN
    .stall_i(stall5),
`endif
    .busy_o(busy5), .done_o(done5), .rd_en_o(rd5), .rd_addr_a_o(ra5), .rd_addr_b_o(rb5),
    .tw_addr_o(tw5), .wr_en_o(wr5), .wr_addr_a_o(wa5), .wr_addr_b_o(wb5)
  );

  typedef struct {
    int a;
    int b;
    int tw;
  } vec_t;
  vec_t tbl[12];

  int checks = 0;
  int errors = 0;
  int cur_cycle = 0;

  // Expected per-cycle read trace, indexed by cycle number after the start edge.
  int exp_rd[0:127];
  int exp_a[0:127];
  int exp_b[0:127];
  int exp_tw[0:127];
  int exp_t;

  int o_rd, o_a, o_b, o_tw, o_wr, o_wa, o_wb, o_busy, o_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cur_cycle, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 3) start3 = v;
    else start5 = v;
  endtask

  task automatic sample(input int sel);
    if (sel == 3) begin
      o_rd = int'(rd3); o_a = int'(ra3); o_b = int'(rb3); o_tw = int'(tw3);
      o_wr = int'(wr3); o_wa = int'(wa3); o_wb = int'(wb3);
      o_busy = int'(busy3); o_done = int'(done3);
    end else begin
      o_rd = int'(rd5); o_a = int'(ra5); o_b = int'(rb5); o_tw = int'(tw5);
      o_wr = int'(wr5); o_wa = int'(wa5); o_wb = int'(wb5);
      o_busy = int'(busy5); o_done = int'(done5);
    end
  endtask

  // Reads in stage order: groups of 2*span samples, pairing p with p+span.
  task automatic build_trace(input int l);
    int n, c, span;
    n = 1 << l;
    for (int i = 0; i < 128; i++) begin
      exp_rd[i] = 0; exp_a[i] = 0; exp_b[i] = 0; exp_tw[i] = 0;
    end
    c = 1;
    for (int s = 0; s < l; s++) begin
      span = 1 << s;
      for (int g = 0; g < n / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          exp_rd[c] = 1;
          exp_a[c]  = g * 2 * span + p;
          exp_b[c]  = g * 2 * span + p + span;
          exp_tw[c] = p * (n / (2 * span));
          c++;
        end
      end
      if (s < l - 1) c++;
    end
    c++;
    exp_t = c;
  endtask

  // Runs one transform from IDLE; start held high for the first 'hold' edges.
  task automatic run_transform(input int sel, input int hold, input bit use_tbl);
    int tidx, nreads;
    build_trace(sel);
    tidx = 0;
    nreads = 0;
    set_start(sel, 1'b1);
    for (int c = 1; c <= exp_t + 1; c++) begin
      step();
      cur_cycle = c;
      set_start(sel, c < hold);
      sample(sel);
      check("rd_en", o_rd, exp_rd[c]);
      check("busy", o_busy, (c <= exp_t) ? 1 : 0);
      check("done", o_done, (c == exp_t) ? 1 : 0);
      check("wr_en", o_wr, exp_rd[c-1]);
      if (exp_rd[c] != 0) begin
        check("rd_addr_a", o_a, exp_a[c]);
        check("rd_addr_b", o_b, exp_b[c]);
        check("tw_addr", o_tw, exp_tw[c]);
        if (use_tbl && tidx < 12) begin
          check("tbl_a", o_a, tbl[tidx].a);
          check("tbl_b", o_b, tbl[tidx].b);
          check("tbl_tw", o_tw, tbl[tidx].tw);
        end
        tidx++;
      end
      if (exp_rd[c-1] != 0) begin
        check("wr_addr_a", o_wa, exp_a[c-1]);
        check("wr_addr_b", o_wb, exp_b[c-1]);
      end
      if (o_rd != 0 && o_wr != 0)
        check("raw_hazard", int'(o_a == o_wa || o_a == o_wb || o_b == o_wa || o_b == o_wb), 0);
      nreads += o_rd;
    end
    check("read_count", nreads, sel * (1 << (sel - 1)));
  endtask

  initial begin
    int sel, gap, hold, tl;
    tbl = '{'{0, 1, 0}, '{2, 3, 0}, '{4, 5, 0}, '{6, 7, 0},
            '{0, 2, 0}, '{1, 3, 2}, '{4, 6, 0}, '{5, 7, 2},
            '{0, 4, 0}, '{1, 5, 1}, '{2, 6, 2}, '{3, 7, 3}};
    rst_n  = 1'b0;
    start3 = 1'b0;
    start5 = 1'b0;
`ifdef FFT_CTRL_STALL_EN
    stall3 = 1'b0;
    stall5 = 1'b0;
`endif

    // Reset state.
    #2;
    sample(3);
    check("rst_busy", o_busy, 0); check("rst_done", o_done, 0);
    check("rst_rd_en", o_rd, 0); check("rst_wr_en", o_wr, 0);
    check("rst_addr", o_a | o_b | o_tw | o_wa | o_wb, 0);
    sample(5);
    check("rst5_busy", o_busy, 0);
    check("rst5_addr", o_a | o_b | o_tw | o_wa | o_wb | o_rd | o_wr | o_done, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single start pulse, then a back-to-back second transform.
    run_transform(3, 1, 1'b1);
    run_transform(3, 1, 1'b1);
    // Start held through the whole transform: exactly one transform.
    run_transform(3, 17, 1'b1);
    step();
    sample(3);
    check("no_second_run", o_busy, 0);

    // Reset mid-stage clears all outputs immediately.
    set_start(3, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      step();
      set_start(3, 1'b0);
    end
    cur_cycle = 6;
    rst_n = 1'b0;
    #1;
    sample(3);
    check("midrst_busy", o_busy, 0); check("midrst_rd_en", o_rd, 0);
    check("midrst_wr_en", o_wr, 0); check("midrst_done", o_done, 0);
    check("midrst_addr", o_a | o_b | o_tw | o_wa | o_wb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    sample(3);
    check("postrst_busy", o_busy, 0);
    check("postrst_rd_en", o_rd, 0);
    run_transform(3, 1, 1'b1);

`ifdef FFT_CTRL_STALL_EN
    // Stall for 3 cycles while stage 1, k=2 is about to be issued.
    begin
      int dc;
      set_start(3, 1'b1);
      for (int c = 1; c <= 7; c++) begin
        step();
        cur_cycle = c;
        set_start(3, 1'b0);
      end
      stall3 = 1'b1;
      for (int c = 8; c <= 10; c++) begin
        step();
        cur_cycle = c;
        sample(3);
        check("stall_rd_en", o_rd, 0);
        check("stall_hold_a", o_a, 1);
        check("stall_hold_b", o_b, 3);
        check("stall_busy", o_busy, 1);
        if (c == 8) begin
          check("stall_inflight_wr", o_wr, 1);
          check("stall_inflight_wa", o_wa, 1);
          check("stall_inflight_wb", o_wb, 3);
        end else begin
          check("stall_no_wr", o_wr, 0);
        end
      end
      stall3 = 1'b0;
      step();
      cur_cycle = 11;
      sample(3);
      check("resume_rd_en", o_rd, 1);
      check("resume_a", o_a, 4);
      check("resume_b", o_b, 6);
      check("resume_tw", o_tw, 0);
      dc = 0;
      for (int c = 12; c <= 40; c++) begin
        step();
        cur_cycle = c;
        sample(3);
        if (o_done != 0 && dc == 0) dc = c;
      end
      check("stall_done_cycle", dc, 19);
    end
`endif

    // Randomised transforms on both sizes: idle gaps and start hold lengths.
    for (int i = 0; i < 8; i++) begin
      sel  = ($urandom_range(0, 1) == 1) ? 5 : 3;
      gap  = $urandom_range(0, 3);
      tl   = sel * (1 << (sel - 1)) + sel + 1;
      hold = $urandom_range(1, tl + 1);
      repeat (gap) step();
      run_transform(sel, hold, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_controller.md
# fft_stage_controller

Sequencer for the in-place radix-2 DIT FFT built around the combinational butterfly datapath. It walks all log2(N) stages and issues one butterfly per cycle. For each butterfly it generates the operand read addresses, the twiddle ROM address and the delayed write-back addresses for a dual-port sample RAM. It sits between the CWT top-level control (start/done) and the butterfly + sample RAM + twiddle ROM. The input samples are already stored in bit-reversed order.

## Interface
- `LOG2N`, default 5: log2 of the FFT length N. Legal range is 2..10.
- `AW`, default `LOG2N`: width of the sample RAM address.
- `clk` input, 1 bit: single clock. All registers update on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a transform. Sampled only in IDLE.
- `busy` output, 1 bit: high in every state other than IDLE.
- `done` output, 1 bit: one-cycle pulse when the last write-back has completed.
- `rd_en` output, 1 bit: read strobe for both RAM ports and the twiddle ROM.
- `rd_addr_a` output, `AW` bits: address of the upper butterfly input (in1).
- `rd_addr_b` output, `AW` bits: address of the lower butterfly input (in2).
- `tw_addr` output, `LOG2N-1` bits: twiddle ROM index.
- `wr_en` output, 1 bit: write strobe for both RAM ports.
- `wr_addr_a` output, `AW` bits: destination of out1.
- `wr_addr_b` output, `AW` bits: destination of out2.
- `stall` input, 1 bit: present only with `FFT_CTRL_STALL_EN`.

## Operation
- **FSM states:** IDLE, RUN, GAP, FLUSH, DONE.
- **Transitions:**
  - IDLE → RUN when `start`=1.
  - RUN → GAP after the last butterfly of stage s, when s < LOG2N-1.
  - GAP → RUN after one cycle, with s incremented.
  - RUN → FLUSH after the last butterfly of the last stage.
  - FLUSH → DONE after one cycle.
  - DONE → IDLE after one cycle.
- **Counters:** stage s runs 0..LOG2N-1; butterfly index k runs 0..N/2-1. k wraps to 0 at each stage end.
- **Address generation (RUN, per k):**
  - span = 1<<s, pos = k & (span-1), grp = k >> s.
  - `rd_addr_a` = (grp << (s+1)) | pos.
  - `rd_addr_b` = `rd_addr_a` + span.
  - `tw_addr` = pos << (LOG2N-1-s).
  - All arithmetic is unsigned and truncated to the port widths; no overflow is possible.
- **Write-back:** `wr_en`, `wr_addr_a` and `wr_addr_b` are copies of `rd_en`, `rd_addr_a` and `rd_addr_b` registered one cycle. RAM and ROM reads are synchronous with one-cycle latency, and the butterfly is combinational. The write therefore lands in the cycle after the read.
- **GAP cycle:** a one-cycle bubble where `rd_en`=0. The last write of stage s completes in this cycle, before stage s+1 reads, so there is no read-after-write hazard across stages.
- **FLUSH cycle:** `rd_en`=0; the final write completes.
- **`start` handling:** ignored in every state except IDLE. It is not queued.
- **Reset:** asynchronous assertion at any time forces:
  - state = IDLE, s = 0, k = 0;
  - all outputs to 0, including the registered write outputs.
  - Any pending write is dropped and the RAM contents are undefined for that transform.

## Timing
- **Reset values:** `busy`, `done`, `rd_en` and `wr_en` are 0; all address outputs are 0.
- **Cycle numbering:** `start` is sampled at edge 0.
  - Cycle 1 is the first RUN cycle: `rd_en`=1, k=0, s=0.
  - `wr_en` first rises in cycle 2.
- **Per stage:** exactly N/2 consecutive `rd_en` cycles when there is no stall.
- **Total latency:** `done` rises in cycle LOG2N·N/2 + (LOG2N-1) + 2 after the `start` edge.
  - N=32: cycle 86.
  - N=8: cycle 16.
- `busy` is high from cycle 1 through the `done` cycle, and low the cycle after.
- **Back-to-back transforms:** `start` asserted in the cycle after `done` is accepted; minimum spacing is 1 IDLE cycle.
- Outputs are registered, with no combinational paths from inputs to outputs.

## Configuration
- **`FFT_CTRL_STALL_EN` defined:**
  - The `stall` port exists.
  - `stall`=1 in RUN holds s and k and forces `rd_en`=0. Addresses hold their last values.
  - The write-back of the butterfly already in flight still completes in the next cycle.
  - `stall` is ignored in IDLE, GAP, FLUSH and DONE.
  - Each stall cycle adds one cycle to the latency.
- **`FFT_CTRL_STALL_EN` undefined:** there is no `stall` port, and the block behaves as if `stall`=0.

## Test plan
- **Reset:** assert `rst`=0 mid-stage with LOG2N=3 → all outputs 0 within the same cycle. After release, FSM in IDLE and `busy`=0.
- **Address sequence, LOG2N=3, one `start` pulse:**
  - (a,b,tw) pairs must be exactly:
    - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0);
    - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2);
    - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - A single `rd_en`=0 gap between stages.
  - `done` pulses in cycle 16.
- **Write alignment:** every `wr_en`/`wr_addr` equals the `rd_en`/`rd_addr` of the previous cycle. No cycle has a read of an address that was written in the same cycle.
- **End-to-end, LOG2N=5:** RAM preloaded with impulse x[0]=0x0100, rest 0, plus butterfly and twiddle ROM → all 32 bins real 0x0100 and imag 0 after `done` at cycle 86.
- **Start handling:** `start` held high for the whole transform → exactly one transform. A second `start` the cycle after `done` launches a second transform with an identical sequence.
- **Stall (macro defined):** `stall`=1 for 3 cycles at stage 1, k=2 → k holds, the in-flight write still happens, and `done` is delayed to cycle 19 for LOG2N=3.
